// File: rtl/cache_line_writeback_pkg.sv
// Shared cache definitions: line geometry defaults, AXI encodings and the
// writeback engine state encoding.
package cache_line_writeback_pkg;

    // Default line geometry; tag + index + line-offset bits span a 32-bit address
    localparam int DEF_CACHE_LINE_WIDTH = 6;
    localparam int DEF_TAG_WIDTH        = 20;
    localparam int DEF_INDEX_WIDTH      = 6;

    // AXI encodings used by the cache write path
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SEND,
        ST_WAIT_B,
        ST_DONE
    } wb_state_e;

endpackage

// File: rtl/cache_line_writeback_line_buffer.sv
// Line-sized register file: synchronous write port, asynchronous read port.
// Shared between the writeback and refill paths.
module line_buffer #(
    parameter int OFFSET_WIDTH = 4,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [OFFSET_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [OFFSET_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int DEPTH = 1 << OFFSET_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Store one word per enabled cycle
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cache_line_writeback.sv
// Dirty-line eviction engine: copies the victim line into a local buffer,
// releases the line for refill, then sends it as one INCR AXI write burst.
module cache_line_writeback
    import cache_line_writeback_pkg::*;
#(
    parameter int CACHE_LINE_WIDTH = DEF_CACHE_LINE_WIDTH,
    parameter int TAG_WIDTH        = DEF_TAG_WIDTH,
    parameter int INDEX_WIDTH      = DEF_INDEX_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_req,
    input  logic [TAG_WIDTH-1:0]         wb_tag,
    input  logic [INDEX_WIDTH-1:0]       wb_index,
    output logic                         wb_busy,
    output logic                         wb_line_free,
    output logic                         wb_done,
    output logic                         wb_err,
    output logic [CACHE_LINE_WIDTH-3:0]  line_roff,
    input  logic [31:0]                  line_rdata,
    output logic [31:0]                  awaddr,
    output logic [7:0]                   awlen,
    output logic [2:0]                   awsize,
    output logic [1:0]                   awburst,
    output logic                         awvalid,
    input  logic                         awready,
    output logic [31:0]                  wdata,
    output logic [3:0]                   wstrb,
    output logic                         wlast,
    output logic                         wvalid,
    input  logic                         wready,
    input  logic [1:0]                   bresp,
    input  logic                         bvalid,
    output logic                         bready
);

    localparam int OFFSET_WIDTH = CACHE_LINE_WIDTH - 2;
    localparam logic [OFFSET_WIDTH-1:0] CNT_MAX = '1;

    wb_state_e               state_q, state_d;
    logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic [INDEX_WIDTH-1:0]  index_q, index_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    err_q, err_d;
    logic                    buf_we;
    logic [31:0]             buf_rdata;

    line_buffer #(
        .OFFSET_WIDTH (OFFSET_WIDTH),
        .DATA_WIDTH   (32)
    ) u_line_buffer (
        .clk   (clk),
        .we    (buf_we),
        .waddr (cnt_q),
        .wdata (line_rdata),
        .raddr (cnt_q),
        .rdata (buf_rdata)
    );

    assign wb_busy = (state_q != ST_IDLE);
    assign wb_err  = err_q;
    assign awaddr  = {tag_q, index_q, {CACHE_LINE_WIDTH{1'b0}}};
    assign awlen   = 8'((1 << OFFSET_WIDTH) - 1);
    assign awsize  = SIZE_4B;
    assign awburst = BURST_INCR;
    assign wstrb   = 4'hF;

    // State and datapath registers; reset drops every valid at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tag_q     <= '0;
            index_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tag_q     <= tag_d;
            index_q   <= index_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
        end
    end

    // Next-state and output decode for capture, burst and response phases
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tag_d        = tag_q;
        index_d      = index_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        err_d        = err_q;
        buf_we       = 1'b0;
        line_roff    = '0;
        wb_line_free = 1'b0;
        wb_done      = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        wlast        = 1'b0;
        wdata        = '0;
        bready       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wb_req) begin
                    tag_d   = wb_tag;
                    index_d = wb_index;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                line_roff = cnt_q;
                buf_we    = 1'b1;
                if (cnt_q == CNT_MAX) begin
                    wb_line_free = 1'b1;
                    cnt_d        = '0;
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                    state_d      = ST_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SEND: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                if (!w_done_q) begin
                    wdata = buf_rdata;
                    wlast = (cnt_q == CNT_MAX);
                end
                if (!aw_done_q && awready) begin
                    aw_done_d = 1'b1;
                end
                if (!w_done_q && wready) begin
                    if (cnt_q == CNT_MAX) begin
                        w_done_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WAIT_B;
                end
            end

            ST_WAIT_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    err_d   = (bresp != RESP_OKAY);
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                wb_done = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_line_writeback.sv
// Self-checking bench for cache_line_writeback: randomized lines, tags and
// handshake patterns compared against a transaction-level expectation.
module tb_cache_line_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_req;
    logic [19:0] wb_tag;
    logic [5:0]  wb_index;
    logic        wb_busy, wb_line_free, wb_done, wb_err;
    logic [3:0]  line_roff;
    logic [31:0] line_rdata;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    logic [31:0] line_mem [16];
    logic        errModel;
    int          total = 0;
    int          bad   = 0;

    cache_line_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .wb_req       (wb_req),
        .wb_tag       (wb_tag),
        .wb_index     (wb_index),
        .wb_busy      (wb_busy),
        .wb_line_free (wb_line_free),
        .wb_done      (wb_done),
        .wb_err       (wb_err),
        .line_roff    (line_roff),
        .line_rdata   (line_rdata),
        .awaddr       (awaddr),
        .awlen        (awlen),
        .awsize       (awsize),
        .awburst      (awburst),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wlast        (wlast),
        .wvalid       (wvalid),
        .wready       (wready),
        .bresp        (bresp),
        .bvalid       (bvalid),
        .bready       (bready)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // The cache line storage answers reads in the same cycle
    assign line_rdata = line_mem[line_roff];

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One complete writeback: request, capture, burst, response
    task automatic applyStimulus(input logic [19:0] tag, input logic [5:0] idx,
                                 input logic [1:0] resp, input int awMode, input int wMode,
                                 input bit midReq, input int resetAfter, input bit patternLine);
        logic [31:0] expWords [16];
        logic [31:0] expAddr;
        logic [31:0] prevData;
        logic        prevLast;
        bit          prevStall, awDone, wDone, bDone, seenFree, awNew, wNew, hsW, hsA, hsB;
        int          cyc, beat, sendCyc;

        for (int i = 0; i < 16; i++) begin
            line_mem[i] = patternLine ? 32'hA500_0000 + 32'(i) : $urandom;
            expWords[i] = line_mem[i];
        end
        expAddr = (32'(tag) << 12) | (32'(idx) << 6);

        @(negedge clk);
        checkOutput("idle_busy", wb_busy, 1'b0);
        checkOutput("err_held_before_req", wb_err, errModel);
        wb_tag   = tag;
        wb_index = idx;
        wb_req   = 1'b1;
        @(negedge clk);
        wb_req   = 1'b0;
        wb_tag   = 20'($urandom);
        wb_index = 6'($urandom);
        checkOutput("busy_capture", wb_busy, 1'b1);
        checkOutput("err_cleared_on_req", wb_err, 1'b0);

        cyc = 1;
        seenFree = 0;
        while (!seenFree && cyc < 40) begin
            if (wb_line_free) seenFree = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput("line_free_latency", 32'(cyc), 32'd16);
        if (!seenFree) return;

        // After the final capture edge the line may be refilled with anything
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) line_mem[i] = $urandom;

        awDone = 0; wDone = 0; bDone = 0; beat = 0; prevStall = 0; sendCyc = 0;
        prevData = '0; prevLast = 1'b0;
        while (!bDone && sendCyc < 300) begin
            @(negedge clk);
            sendCyc++;
            checkOutput("awvalid", awvalid, !awDone);
            checkOutput("wvalid", wvalid, !wDone);
            checkOutput("bready", bready, awDone && wDone);
            if (awvalid) begin
                checkOutput("awaddr", awaddr, expAddr);
                checkOutput("aw_const", {awlen, awsize, awburst, wstrb}, {8'd15, 3'b010, 2'b01, 4'hF});
            end
            if (wvalid && prevStall) begin
                checkOutput("wdata_stable", wdata, prevData);
                checkOutput("wlast_stable", wlast, prevLast);
            end
            if (wvalid && beat < 16) begin
                checkOutput("wdata", wdata, expWords[beat]);
                checkOutput("wlast", wlast, beat == 15);
            end

            if (resetAfter >= 0 && beat == resetAfter) begin
                #2 rst = 1'b1;
                #1;
                checkOutput("rst_awvalid", awvalid, 1'b0);
                checkOutput("rst_wvalid", wvalid, 1'b0);
                checkOutput("rst_busy", wb_busy, 1'b0);
                awready = 1'b0;
                wready  = 1'b0;
                bvalid  = 1'b0;
                errModel = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                checkOutput("post_rst_busy", wb_busy, 1'b0);
                checkOutput("post_rst_err", wb_err, 1'b0);
                return;
            end

            case (wMode)
                0:       wNew = 1;
                1:       wNew = (sendCyc % 3 == 1);
                default: wNew = bit'($urandom_range(0, 1));
            endcase
            case (awMode)
                0:       awNew = 1;
                1:       awNew = wDone;
                default: awNew = bit'($urandom_range(0, 1));
            endcase
            if (midReq && sendCyc == 3) begin
                wb_req = 1'b1;
                wb_tag = ~tag;
            end else begin
                wb_req = 1'b0;
            end
            bvalid = wDone;
            bresp  = wDone ? resp : 2'b00;

            hsW = wvalid && wNew;
            hsA = awvalid && awNew;
            hsB = bvalid && bready;
            wready  = wNew;
            awready = awNew;
            prevStall = wvalid && !wNew;
            prevData  = wdata;
            prevLast  = wlast;
            if (hsW) begin
                beat++;
                if (beat == 16) wDone = 1;
            end
            if (hsA) awDone = 1;
            if (hsB) bDone = 1;
        end
        if (!bDone) begin
            checkOutput("b_handshake_timeout", 32'd0, 32'd1);
            return;
        end

        @(negedge clk);
        bvalid  = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        errModel = (resp != 2'b00);
        checkOutput("wb_done", wb_done, 1'b1);
        checkOutput("wb_err", wb_err, errModel);
        checkOutput("beat_count", 32'(beat), 32'd16);
        wb_req = 1'b1;
        wb_tag = 20'($urandom);
        @(negedge clk);
        wb_req = 1'b0;
        checkOutput("done_pulse_width", wb_done, 1'b0);
        checkOutput("req_in_done_ignored", wb_busy, 1'b0);
        checkOutput("err_hold_idle", wb_err, errModel);
        checkOutput("no_second_burst", awvalid, 1'b0);
    endtask

    // Directed scenarios followed by fully randomized writebacks
    initial begin
        rst = 1'b1;
        wb_req = 1'b0; wb_tag = '0; wb_index = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        errModel = 1'b0;
        for (int i = 0; i < 16; i++) line_mem[i] = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ctrl", {24'b0, wb_busy, wb_line_free, wb_done, wb_err,
                                 awvalid, wvalid, wlast, bready}, 32'd0);
        checkOutput("rst_awaddr", awaddr, 32'd0);
        checkOutput("rst_wdata", wdata, 32'd0);
        checkOutput("rst_roff", {28'b0, line_roff}, 32'd0);
        rst = 1'b0;

        $display("[TB] basic writeback");
        applyStimulus(20'h12345, 6'h2A, 2'b00, 0, 0, 0, -1, 1);
        $display("[TB] W backpressure");
        applyStimulus(20'($urandom), 6'($urandom), 2'b00, 0, 1, 0, -1, 0);
        $display("[TB] AW late");
        applyStimulus(20'($urandom), 6'($urandom), 2'b00, 1, 0, 0, -1, 0);
        $display("[TB] error response");
        applyStimulus(20'($urandom), 6'($urandom), 2'b10, 2, 2, 0, -1, 0);
        applyStimulus(20'($urandom), 6'($urandom), 2'b00, 2, 2, 0, -1, 0);
        $display("[TB] request while busy");
        applyStimulus(20'($urandom), 6'($urandom), 2'b00, 0, 1, 1, -1, 0);
        $display("[TB] reset during burst");
        applyStimulus(20'($urandom), 6'($urandom), 2'b00, 0, 0, 0, 5, 0);
        applyStimulus(20'($urandom), 6'($urandom), 2'b00, 0, 0, 0, -1, 0);
        $display("[TB] random writebacks");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(20'($urandom), 6'($urandom), 2'($urandom_range(0, 3)),
                          $urandom_range(0, 2), $urandom_range(0, 2), 0, -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_line_writeback.md
Name: cache_line_writeback

Overview:
- Eviction engine for a dirty cache line, placed between one cache way's line storage and the AXI write channels.
- On a request, it reads the victim line word-by-word through the line's read-offset port into an internal buffer, then frees the line for refill.
- It then issues one INCR AXI write burst (AW/W) and waits for the B response.
- It is the read/transmit counterpart of the line-fill path, which writes AXI read data into the line.

Parameters:
- CACHE_LINE_WIDTH, 6, log2 of line bytes; 64 B line = 16 words.
- TAG_WIDTH, 20, tag bits.
- INDEX_WIDTH, 6, set index bits. TAG_WIDTH+INDEX_WIDTH+CACHE_LINE_WIDTH must equal 32.
- OFFSET_WIDTH, CACHE_LINE_WIDTH-2, word-offset bits; derived, not overridden.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_req  in  1  start writeback. Sampled only in IDLE.
- wb_tag  in  TAG_WIDTH  victim tag. Captured with wb_req.
- wb_index  in  INDEX_WIDTH  victim set index. Captured with wb_req.
- wb_busy  out  1  high in every state except IDLE.
- wb_line_free  out  1  1-cycle pulse when the last word is buffered; the line may be overwritten from the next cycle.
- wb_done  out  1  1-cycle pulse after the B handshake.
- wb_err  out  1  valid with wb_done; high when bresp != OKAY.
- line_roff  out  OFFSET_WIDTH  word offset presented to the line read port.
- line_rdata  in  32  asynchronous (same-cycle) read data for line_roff.
- awaddr  out  32 ; awlen  out  8 ; awsize  out  3 ; awburst  out  2 ; awvalid  out  1 ; awready  in  1
- wdata  out  32 ; wstrb  out  4 ; wlast  out  1 ; wvalid  out  1 ; wready  in  1
- bresp  in  2 ; bvalid  in  1 ; bready  out  1

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. A reset mid-burst drops all valids immediately; this is accepted because it is a system-wide reset.
- Constant outputs: awlen = 2^OFFSET_WIDTH-1 (15); awsize = 3'b010; awburst = 2'b01; wstrb = 4'hF.
- awaddr = {tag_q, index_q, CACHE_LINE_WIDTH'b0}, registered at request accept.
- IDLE:
  - wb_req=1 captures tag and index, clears cnt, and moves to CAPTURE.
  - line_roff = 0 while idle.
- CAPTURE:
  - Each cycle, line_roff = cnt and buf[cnt] <= line_rdata; cnt increments.
  - At cnt = max, wb_line_free pulses in the same cycle as the final capture, cnt clears, and the state moves to SEND.
  - Latency from wb_req to wb_line_free: 16 cycles.
- SEND:
  - awvalid and wvalid both assert on SEND entry; AW and W run independently.
  - awvalid holds until awready, then sets aw_done.
  - wdata = buf[cnt]; cnt advances only on wvalid & wready.
  - wlast = (cnt == max).
  - wvalid deasserts after the last beat handshake and sets w_done.
  - wdata, wlast and awaddr stay stable while valid is high and ready is low.
  - When aw_done & w_done (including the case where both complete in the same cycle), move to WAIT_B.
- WAIT_B:
  - bready = 1.
  - On bvalid, latch wb_err = (bresp != 2'b00) and move to DONE.
- DONE:
  - Pulse wb_done for one cycle with wb_err held valid, then return to IDLE.
  - wb_err clears on the next accepted request.
- Simultaneous events:
  - wb_req outside IDLE is ignored; the requester must wait for wb_busy=0.
  - wb_req in the DONE cycle is ignored.
- Back-to-back writebacks: minimum 1 IDLE cycle between them.
- bvalid arriving before SEND completes: it cannot be accepted (bready=0); it is held by the slave.

Decomposition:
- Shared cache package holds:
  - the AXI constants: BURST_INCR = 2'b01, SIZE_4B = 3'b010, RESP_OKAY = 2'b00;
  - the state encoding (IDLE, CAPTURE, SEND, WAIT_B, DONE);
  - the line geometry parameters.
- One natural sub-module: line_buffer, a 2^OFFSET_WIDTH x 32 register file with a sync write port and an async read port. It is reused by the refill path.

Test Plan:
- Basic writeback:
  - Stimulus: wb_tag=20'h12345, wb_index=6'h2A, line word i = 32'hA5000000+i; awready and wready always 1; bvalid one cycle after the last W beat with bresp=0.
  - Required: awaddr=32'h12345A80 and awlen=15; wb_line_free at cycle 16; 16 W beats carrying A5000000..A500000F with wlast only on beat 15; wb_done with wb_err=0.
- W backpressure: wready toggles 1,0,0,1... -> wdata and wlast are stable during stalls; the beat order is exact; the total beat count is 16.
- AW late: awready held 0 until after all W beats complete -> no transition to WAIT_B until the AW handshake; bready stays 0 before that.
- Error response: bresp=2'b10 -> wb_done=1 with wb_err=1; the next request clears wb_err.
- Request while busy: wb_req pulsed during SEND with a different tag -> ignored; awaddr unchanged and only one burst is issued.
- Reset during SEND after 5 W beats: rst=1 -> awvalid, wvalid and wb_busy go 0 immediately (asynchronous); after release the state is IDLE and a new request runs normally.
